// File: rtl/atm_keypad_requester_pkg.sv
// Shared definitions for the ATM keypad requester: operation codes (common
// with the ATM core), keypad codes and the requester's state encoding.
package atm_keypad_requester_pkg;

    typedef enum logic [2:0] {
        OP_NONE       = 3'd0,
        OP_BALANCE    = 3'd1,
        OP_WITHDRAW   = 3'd2,
        OP_DEPOSIT    = 3'd3,
        OP_CHANGE_PIN = 3'd4,
        OP_EXIT       = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PIN_ENTRY    = 3'd1,
        S_OP_SELECT    = 3'd2,
        S_AMOUNT_ENTRY = 3'd3,
        S_NEWPIN_ENTRY = 3'd4,
        S_ISSUE        = 3'd5,
        S_WAIT_RSP     = 3'd6,
        S_LOCKED       = 3'd7
    } state_e;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_entry(input state_e s);
        return s inside {S_PIN_ENTRY, S_OP_SELECT, S_AMOUNT_ENTRY, S_NEWPIN_ENTRY};
    endfunction

endpackage

// File: rtl/atm_keypad_requester_bcd_entry_buffer.sv
// Keypad digit accumulator: packed BCD shift (PIN) or binary decimal
// accumulate (amount), with digit count and saturation at DIGITS.
module atm_bcd_entry_buffer #(
    parameter int DIGITS = 4,
    parameter bit BINARY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        digit_valid_i,
    input  logic [3:0]  digit_i,
    output logic [15:0] value_o,
    output logic [2:0]  count_o
);
    import atm_keypad_requester_pkg::*;

    logic [15:0] value_q, value_d;
    logic [2:0]  count_q, count_d;

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear_i) begin
            value_d = '0;
            count_d = '0;
        end else if (digit_valid_i && count_q < 3'(DIGITS)) begin
            if (BINARY) begin
                value_d = value_q * 16'd10 + {12'd0, digit_i};
            end else begin
                value_d = {value_q[11:0], digit_i};
            end
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value_o = value_q;
    assign count_o = count_q;

endmodule

// File: rtl/atm_keypad_requester.sv
// Keypad front-end for the ATM core: collects PIN/operation/amount/new PIN,
// issues one request on valid/ready, tracks auth retries and idle timeout.
module atm_keypad_requester #(
    parameter int PIN_DIGITS     = 4,
    parameter int AMT_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_PIN_TRIES  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        card_inserted,
    input  logic [3:0]  card_acc_num,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [2:0]  req_operation,
    output logic [3:0]  req_acc_num,
    output logic [15:0] req_pin,
    output logic [15:0] req_new_pin,
    output logic [15:0] req_amount,
    input  logic        rsp_valid,
    input  logic        rsp_auth_fail,
    output logic        locked,
    output logic [2:0]  digit_count,
    output logic [2:0]  state
);
    import atm_keypad_requester_pkg::*;

    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [3:0]        acc_q, acc_d;
    logic [15:0]       pin_q, pin_d;
    logic [15:0]       new_pin_q, new_pin_d;
    logic [15:0]       amount_q, amount_d;
    logic              req_valid_q, locked_q;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic        in_entry, pin_mode, amt_mode, removed;
    logic        key_digit, key_enter, key_clear, key_cancel, timeout_hit;
    logic [15:0] pin_val, amt_val;
    logic [2:0]  pin_cnt, amt_cnt;

    assign in_entry    = is_entry(state_q);
    assign pin_mode    = (state_q == S_PIN_ENTRY) || (state_q == S_NEWPIN_ENTRY);
    assign amt_mode    = (state_q == S_AMOUNT_ENTRY);
    assign removed     = (state_q != S_IDLE) && !card_inserted;
    assign key_digit   = key_valid && is_digit(key_code);
    assign key_enter   = key_valid && (key_code == KEY_ENTER);
    assign key_clear   = key_valid && (key_code == KEY_CLEAR);
    assign key_cancel  = key_valid && (key_code == KEY_CANCEL);
    assign timeout_hit = in_entry && !key_valid && (tmo_q == '0);

    // Buffers are held clear outside their own entry states, so every entry starts empty.
    atm_bcd_entry_buffer #(.DIGITS(PIN_DIGITS), .BINARY(1'b0)) u_pin_buf (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (!pin_mode || key_clear),
        .digit_valid_i (pin_mode && key_digit && card_inserted),
        .digit_i       (key_code),
        .value_o       (pin_val),
        .count_o       (pin_cnt)
    );

    atm_bcd_entry_buffer #(.DIGITS(AMT_DIGITS), .BINARY(1'b1)) u_amt_buf (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (!amt_mode || key_clear),
        .digit_valid_i (amt_mode && key_digit && card_inserted),
        .digit_i       (key_code),
        .value_o       (amt_val),
        .count_o       (amt_cnt)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        pin_d     = pin_q;
        new_pin_d = new_pin_q;
        amount_d  = amount_q;
        tries_d   = tries_q;

        if (removed) begin
            state_d   = S_IDLE;
            op_d      = OP_NONE;
            acc_d     = '0;
            pin_d     = '0;
            new_pin_d = '0;
            amount_d  = '0;
            tries_d   = '0;
        end else if (in_entry && (key_cancel || timeout_hit)) begin
            state_d   = S_ISSUE;
            op_d      = OP_EXIT;
            new_pin_d = '0;
            amount_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (card_inserted) begin
                        state_d = S_PIN_ENTRY;
                        acc_d   = card_acc_num;
                    end
                end
                S_PIN_ENTRY: begin
                    if (key_enter && pin_cnt == 3'(PIN_DIGITS)) begin
                        state_d = S_OP_SELECT;
                        pin_d   = pin_val;
                    end
                end
                S_OP_SELECT: begin
                    if (key_valid) begin
                        case (key_code)
                            4'd1: begin
                                state_d = S_ISSUE; op_d = OP_BALANCE;
                                new_pin_d = '0; amount_d = '0;
                            end
                            4'd2: begin state_d = S_AMOUNT_ENTRY; op_d = OP_WITHDRAW; end
                            4'd3: begin state_d = S_AMOUNT_ENTRY; op_d = OP_DEPOSIT; end
                            4'd4: begin state_d = S_NEWPIN_ENTRY; op_d = OP_CHANGE_PIN; end
                            4'd5: begin
                                state_d = S_ISSUE; op_d = OP_EXIT;
                                new_pin_d = '0; amount_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_AMOUNT_ENTRY: begin
                    if (key_enter && amt_val != '0) begin
                        state_d   = S_ISSUE;
                        amount_d  = amt_val;
                        new_pin_d = '0;
                    end
                end
                S_NEWPIN_ENTRY: begin
                    if (key_enter && pin_cnt == 3'(PIN_DIGITS)) begin
                        state_d   = S_ISSUE;
                        op_d      = OP_CHANGE_PIN;
                        new_pin_d = pin_val;
                        amount_d  = '0;
                    end
                end
                S_ISSUE: begin
                    if (req_ready) state_d = S_WAIT_RSP;
                end
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (rsp_auth_fail) begin
                            tries_d = tries_q + 1'b1;
                            state_d = (tries_d == TRY_W'(MAX_PIN_TRIES)) ? S_LOCKED : S_PIN_ENTRY;
                        end else begin
                            tries_d = '0;
                            if (op_q == OP_EXIT) begin
                                state_d   = S_IDLE;
                                op_d      = OP_NONE;
                                acc_d     = '0;
                                pin_d     = '0;
                                new_pin_d = '0;
                                amount_d  = '0;
                            end else begin
                                state_d = S_OP_SELECT;
                                if (op_q == OP_CHANGE_PIN) pin_d = new_pin_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        // Any key (even an ignored one) or state change restarts the idle window.
        if (key_valid || state_d != state_q) tmo_d = TMO_RELOAD;
        else if (tmo_q != '0)                 tmo_d = tmo_q - 1'b1;
        else                                  tmo_d = tmo_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            acc_q       <= '0;
            pin_q       <= '0;
            new_pin_q   <= '0;
            amount_q    <= '0;
            req_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            tries_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            pin_q       <= pin_d;
            new_pin_q   <= new_pin_d;
            amount_q    <= amount_d;
            req_valid_q <= (state_d == S_ISSUE);
            locked_q    <= (state_d == S_LOCKED);
            tries_q     <= tries_d;
            tmo_q       <= tmo_d;
        end
    end

    assign req_valid     = req_valid_q;
    assign req_operation = op_q;
    assign req_acc_num   = acc_q;
    assign req_pin       = pin_q;
    assign req_new_pin   = new_pin_q;
    assign req_amount    = amount_q;
    assign locked        = locked_q;
    assign state         = state_q;
    assign digit_count   = pin_mode ? pin_cnt : (amt_mode ? amt_cnt : 3'd0);

endmodule

// File: tb/tb_atm_keypad_requester.sv
// Directed bench for atm_keypad_requester with hand-computed expectations.
module tb_atm_keypad_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        card_inserted;
    logic [3:0]  card_acc_num;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_operation;
    logic [3:0]  req_acc_num;
    logic [15:0] req_pin;
    logic [15:0] req_new_pin;
    logic [15:0] req_amount;
    logic        rsp_valid;
    logic        rsp_auth_fail;
    logic        locked;
    logic [2:0]  digit_count;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    localparam int T = 1000;

    always #5 clk = ~clk;

    atm_keypad_requester dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .card_inserted (card_inserted),
        .card_acc_num  (card_acc_num),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operation (req_operation),
        .req_acc_num   (req_acc_num),
        .req_pin       (req_pin),
        .req_new_pin   (req_new_pin),
        .req_amount    (req_amount),
        .rsp_valid     (rsp_valid),
        .rsp_auth_fail (rsp_auth_fail),
        .locked        (locked),
        .digit_count   (digit_count),
        .state         (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic respond(input logic fail);
        rsp_valid     = 1'b1;
        rsp_auth_fail = fail;
        tick();
        rsp_valid     = 1'b0;
        rsp_auth_fail = 1'b0;
    endtask

    task automatic enter_pin(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
        press(d0); press(d1); press(d2); press(d3); press(4'hA);
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_code = '0; card_inserted = 1'b0;
        card_acc_num = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_auth_fail = 1'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pin", req_pin, 0);
        rst = 1'b1;
        tick();

        // withdraw 50 from account 7
        card_acc_num = 4'd7; card_inserted = 1'b1;
        tick();
        chk("t1_pin_state", state, 1);
        chk("t1_acc", req_acc_num, 7);
        press(1); press(2); press(3); press(4);
        chk("t1_pin_count", digit_count, 4);
        press(4'hA);
        chk("t1_opsel", state, 2);
        chk("t1_pin", req_pin, 16'h1234);
        press(2);
        chk("t1_amt_state", state, 3);
        press(5); press(0);
        chk("t1_amt_count", digit_count, 2);
        req_ready = 1'b1;
        press(4'hA);
        chk("t1_issue", state, 5);
        chk("t1_valid", req_valid, 1);
        chk("t1_op", req_operation, 2);
        chk("t1_amount", req_amount, 50);
        chk("t1_newpin", req_new_pin, 0);
        tick();
        chk("t1_wait", state, 6);
        chk("t1_valid_drop", req_valid, 0);
        respond(1'b0);
        chk("t1_rsp_ok", state, 2);

        // cancel -> EXIT, then short-ENTER and CLEAR handling
        press(4'hC);
        chk("t2_cancel_issue", state, 5);
        chk("t2_cancel_op", req_operation, 5);
        chk("t2_cancel_amt", req_amount, 0);
        tick();
        card_acc_num = 4'd3;
        respond(1'b0);
        chk("t2_exit_idle", state, 0);
        chk("t2_exit_acc", req_acc_num, 0);
        tick();
        chk("t2_reenter", state, 1);
        chk("t2_acc", req_acc_num, 3);
        press(1); press(2); press(4'hA);
        chk("t2_short_enter", state, 1);
        press(5); press(4'hB);
        chk("t2_clear_count", digit_count, 0);
        enter_pin(1, 1, 1, 1);
        chk("t2_opsel", state, 2);
        chk("t2_pin", req_pin, 16'h1111);

        // three auth failures -> lockout
        for (int i = 0; i < 3; i++) begin
            press(1);
            chk("t3_balance_op", req_operation, 1);
            tick();
            respond(1'b1);
            if (i < 2) begin
                chk("t3_retry_state", state, 1);
                chk("t3_retry_count", digit_count, 0);
                chk("t3_retry_locked", locked, 0);
                enter_pin(1, 1, 1, 1);
            end else begin
                chk("t3_locked_state", state, 7);
                chk("t3_locked", locked, 1);
            end
        end
        press(1);
        chk("t3_key_ignored", state, 7);
        card_inserted = 1'b0;
        tick();
        chk("t3_removed_state", state, 0);
        chk("t3_unlocked", locked, 0);

        // amount saturation, zero-amount ENTER, stall and abort
        card_acc_num = 4'd9; card_inserted = 1'b1; req_ready = 1'b0;
        tick();
        enter_pin(1, 2, 3, 4);
        chk("t4_opsel_after_lock", state, 2);
        press(3);
        press(0); press(4'hA);
        chk("t4_zero_enter", state, 3);
        chk("t4_zero_valid", req_valid, 0);
        press(4'hB);
        press(9); press(9); press(9); press(9); press(9);
        chk("t4_sat_count", digit_count, 4);
        press(4'hA);
        chk("t4_issue", state, 5);
        chk("t4_amount", req_amount, 9999);
        chk("t4_op", req_operation, 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_valid", req_valid, 1);
            chk("t4_stall_amount", req_amount, 9999);
            chk("t4_stall_acc", req_acc_num, 9);
        end
        card_inserted = 1'b0;
        tick();
        chk("t4_abort_valid", req_valid, 0);
        chk("t4_abort_state", state, 0);
        chk("t4_abort_amount", req_amount, 0);

        // change PIN
        card_inserted = 1'b1;
        tick();
        enter_pin(1, 2, 3, 4);
        press(4);
        chk("t5_newpin_state", state, 4);
        chk("t5_newpin_count", digit_count, 0);
        enter_pin(5, 6, 7, 8);
        chk("t5_issue", state, 5);
        chk("t5_op", req_operation, 4);
        chk("t5_newpin", req_new_pin, 16'h5678);
        chk("t5_oldpin", req_pin, 16'h1234);
        chk("t5_amount", req_amount, 0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        respond(1'b0);
        chk("t5_back_opsel", state, 2);
        chk("t5_pin_updated", req_pin, 16'h5678);

        // inactivity timeout in OP_SELECT
        repeat (T - 1) tick();
        chk("t6_before_expiry", state, 2);
        tick();
        chk("t6_timeout_issue", state, 5);
        chk("t6_timeout_op", req_operation, 5);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        respond(1'b0);
        chk("t6_idle", state, 0);
        tick();
        enter_pin(1, 2, 3, 4);
        chk("t6_opsel", state, 2);
        repeat (T - 1) tick();
        press(9);
        chk("t6_key_wins", state, 2);
        repeat (T - 1) tick();
        chk("t6_reloaded", state, 2);
        tick();
        chk("t6_second_timeout", state, 5);
        card_inserted = 1'b0;
        tick();
        chk("t6_end_idle", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atm_keypad_requester.md
Name: atm_keypad_requester

Overview:
Front-end initiator for the ATM transaction core. It collects keypad presses for the card's account, PIN, operation, amount and new PIN, and packs them into one request. The request is issued on a valid/ready handshake, and the block then waits for the core's response. It also owns PIN-retry lockout and the inactivity timeout, so the core only ever sees complete, well-formed requests.

Parameters:
PIN_DIGITS, 4, BCD digits in a PIN (packed 4 bits per digit into 16 bits)
AMT_DIGITS, 4, max decimal digits in an amount (max 9999)
TIMEOUT_CYCLES, 1000, idle cycles in an entry state before an automatic EXIT
MAX_PIN_TRIES, 3, consecutive auth failures before lockout

Ports:
clk  in  1  clock
rst  in  1  reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; 0xA ENTER; 0xB CLEAR; 0xC CANCEL; 0xD-0xF ignored
card_inserted  in  1  level, card present
card_acc_num  in  4  account number read from card
req_valid  out  1  request valid
req_ready  in  1  core accepts request
req_operation  out  3  operation code
req_acc_num  out  4  latched account
req_pin  out  16  packed BCD PIN
req_new_pin  out  16  packed BCD new PIN (CHANGE_PIN only, else 0)
req_amount  out  16  binary amount (WITHDRAW/DEPOSIT only, else 0)
rsp_valid  in  1  one-cycle response strobe
rsp_auth_fail  in  1  qualifies rsp_valid: PIN rejected
locked  out  1  lockout active
digit_count  out  3  digits in the current entry buffer
state  out  3  current FSM state

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. All outputs and registers go to 0; state=IDLE; try counter=0; timeout counter=0.
- States: IDLE, PIN_ENTRY, OP_SELECT, AMOUNT_ENTRY, NEWPIN_ENTRY, ISSUE, WAIT_RSP, LOCKED.
- IDLE: card_inserted=1 -> latch card_acc_num into req_acc_num, clear the buffers, go to PIN_ENTRY.
- PIN_ENTRY and NEWPIN_ENTRY:
  - Digit: buffer <= {buffer[11:0], digit}, count+1. Digits after PIN_DIGITS are ignored.
  - ENTER with count==PIN_DIGITS: PIN_ENTRY -> OP_SELECT; NEWPIN_ENTRY -> ISSUE with op CHANGE_PIN. ENTER with fewer digits is ignored.
  - CLEAR: buffer=0, count=0.
- OP_SELECT:
  - Digits 1-5 select BALANCE(1), WITHDRAW(2), DEPOSIT(3), CHANGE_PIN(4), EXIT(5).
  - BALANCE and EXIT -> ISSUE. WITHDRAW and DEPOSIT -> AMOUNT_ENTRY. CHANGE_PIN -> NEWPIN_ENTRY.
  - All other digits, ENTER and CLEAR are ignored.
- AMOUNT_ENTRY:
  - Digit: amount <= amount*10 + d, only while count<AMT_DIGITS; further digits ignored.
  - ENTER with amount!=0 -> ISSUE. ENTER with amount==0 is ignored.
  - CLEAR zeroes amount and count.
- CANCEL in any entry state: op=EXIT -> ISSUE.
- Timeout: counter reloads on every key_valid and on every state change. When it reaches TIMEOUT_CYCLES in an entry state -> op=EXIT, go to ISSUE. If key_valid and timeout expiry coincide, the key wins.
- ISSUE:
  - req_valid=1 from the cycle after entry.
  - All req_* fields stay stable until the cycle where req_valid & req_ready is sampled high, then go to WAIT_RSP and drop req_valid.
  - Acceptance latency: 0 extra cycles when req_ready is already high.
- WAIT_RSP, on rsp_valid:
  - rsp_auth_fail=1: tries+1. If tries reaches MAX_PIN_TRIES -> LOCKED; otherwise -> PIN_ENTRY with the PIN buffer cleared.
  - Success: tries=0. CHANGE_PIN copies new PIN into req_pin. EXIT -> IDLE (all cleared); others -> OP_SELECT.
- LOCKED: locked=1; all keys ignored; leaves only on card removal.
- Card removal (card_inserted=0) in any state except IDLE:
  - Next cycle state=IDLE; all fields, buffers, tries and locked cleared.
  - req_valid drops even without a handshake; this is the only legal abort.
  - Removal has priority over key_valid and rsp_valid in the same cycle.
- key_valid in ISSUE and WAIT_RSP is ignored. rsp_valid outside WAIT_RSP is ignored.
- digit_count shows the active buffer count; 0 in non-entry states.

Decomposition:
- Shared definitions package holds:
  - operation codes (BALANCE=1, WITHDRAW=2, DEPOSIT=3, CHANGE_PIN=4, EXIT=5), matching the ATM core;
  - key codes (ENTER, CLEAR, CANCEL);
  - state encodings for this block.
- One sub-module, atm_bcd_entry_buffer: digit shift/accumulate, count, clear, saturation, in packed-BCD or binary-decimal mode. It is instantiated twice, once for PIN/new PIN and once for amount.

Test Plan:
- Card acc 7, keys 1,2,3,4,ENTER,2,5,0,ENTER, req_ready=1 -> req_valid one cycle; op=2, acc=7, pin=0x1234, amount=50; rsp ok -> OP_SELECT.
- Key sequences 1,2,ENTER then 5,CLEAR,1,1,1,1,ENTER -> the first ENTER is ignored; the final pin is 0x1111.
- Three requests each answered rsp_auth_fail -> PIN_ENTRY twice, then LOCKED, locked=1; card removal -> IDLE, locked=0.
- Amount keys 9,9,9,9,9,ENTER -> amount=9999; ENTER with amount 0 -> no request.
- Hold req_ready=0 for 5 cycles in ISSUE -> fields stable, req_valid stays 1; remove card -> req_valid=0 next cycle, IDLE.
- No keys for TIMEOUT_CYCLES in OP_SELECT -> EXIT request issued; rsp ok -> IDLE. A key in the expiry cycle prevents the timeout.
